// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding mux select encodings (FWD_NONE / FWD_WB / FWD_MEM)
//   - divide sequencer state encoding (IDLE / BUSY)
//   - reg_hit(): register-field match that never matches r0
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  // r0 is hard-wired zero, so a dependency on it is never a hazard.
  function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of the datapath-facing signals of the hazard controller.
//   master : datapath side (drives register fields / control bits,
//            receives stall, flush and forward controls)
//   slave  : hazard controller side
// Signals:
//   rsD, rtD, rsE, rtE                 source registers in D / E
//   writeregE/M/W, RegWriteE/M/W       destination and write enable per stage
//   MemtoRegE/M                        load in E / M
//   branchD, redirectD                 branch compare / taken redirect in D
//   divstartE                          divide present in E
//   stallF/D/E, flushD/E/M             pipeline register controls
//   forwardAD/BD, forwardAE/BE         forwarding mux selects
//   divdoneE                           divide result valid this cycle
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;

  logic [4:0] rsD;
  logic [4:0] rtD;
  logic [4:0] rsE;
  logic [4:0] rtE;
  logic [4:0] writeregE;
  logic [4:0] writeregM;
  logic [4:0] writeregW;
  logic       RegWriteE;
  logic       RegWriteM;
  logic       RegWriteW;
  logic       MemtoRegE;
  logic       MemtoRegM;
  logic       branchD;
  logic       redirectD;
  logic       divstartE;

  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic       forwardAD;
  logic       forwardBD;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       divdoneE;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output branchD, redirectD, divstartE,
    input  stallF, stallD, stallE, flushD, flushE, flushM,
    input  forwardAD, forwardBD, forwardAE, forwardBE, divdoneE
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  branchD, redirectD, divstartE,
    output stallF, stallD, stallE, flushD, flushE, flushM,
    output forwardAD, forwardBD, forwardAE, forwardBE, divdoneE
  );

endinterface

// File: rtl/div_stall_fsm.sv
// ---------------------------------------------------------------------------
// div_stall_fsm
// Tracks occupancy of the execute stage by a multi-cycle divide.
// A divide entering E while IDLE holds E for DIV_CYCLES cycles in total:
// busy for DIV_CYCLES-1 cycles, then one cycle with o_divdone while the
// divide leaves E.
// Ports:
//   i_clk, i_rst_n  core clock, asynchronous active-low reset
//   i_divstart      divide instruction present in E
//   o_divbusy       E occupied by an unfinished divide (drives stalls)
//   o_divdone       divide result valid this cycle
// ---------------------------------------------------------------------------
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_divstart,
  output logic o_divbusy,
  output logic o_divdone
);

  localparam int CW = ($clog2(DIV_CYCLES) > 5) ? $clog2(DIV_CYCLES) : 5;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 2);

  div_state_e    r_state;
  logic [CW-1:0] r_cnt;

  // Divide sequencer: load the down-counter on entry, count to zero, return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (i_divstart) begin
            r_cnt   <= CNT_LOAD;
            r_state <= BUSY;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY: begin
          // divstart is the same held instruction while BUSY; ignore it.
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Busy already in the entry cycle so the front end stalls without delay.
  assign o_divbusy = ((r_state == IDLE) && i_divstart) ||
                     ((r_state == BUSY) && (r_cnt != {CW{1'b0}}));
  assign o_divdone = (r_state == BUSY) && (r_cnt == {CW{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage MIPS core: forwarding
// selects for D and E, load-use and branch stalls, redirect flush, and
// multi-cycle divide occupancy of E.
// Ports:
//   clk    core clock
//   reset  asynchronous active-low reset
//   hz     hazard_ctrl_if.slave (register fields, control bits, controls out)
// Build option:
//   HAZ_DIV_EN  defined   -> multi-cycle divide sequencer (div_stall_fsm)
//               undefined -> single-cycle divide, divdoneE = divstartE
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic       w_divbusy;
  logic       w_divdone;
  logic       w_lwstall;
  logic       w_brstall;
  logic       w_stall;
  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;

`ifdef HAZ_DIV_EN
  div_stall_fsm #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_stall_fsm (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_divstart (hz.divstartE),
    .o_divbusy  (w_divbusy),
    .o_divdone  (w_divdone)
  );
`else
  logic w_unused;
  assign w_unused  = &{1'b0, clk, reset, DIV_CYCLES[0]};
  assign w_divbusy = 1'b0;
  assign w_divdone = hz.divstartE;
`endif

  // E-stage forward selects; the younger result in M takes priority over W.
  always_comb begin
    w_fwd_ae = FWD_NONE;
    w_fwd_be = FWD_NONE;
    if (reg_hit(hz.rsE, hz.writeregM) && hz.RegWriteM) begin
      w_fwd_ae = FWD_MEM;
    end else if (reg_hit(hz.rsE, hz.writeregW) && hz.RegWriteW) begin
      w_fwd_ae = FWD_WB;
    end else begin
      w_fwd_ae = FWD_NONE;
    end
    if (reg_hit(hz.rtE, hz.writeregM) && hz.RegWriteM) begin
      w_fwd_be = FWD_MEM;
    end else if (reg_hit(hz.rtE, hz.writeregW) && hz.RegWriteW) begin
      w_fwd_be = FWD_WB;
    end else begin
      w_fwd_be = FWD_NONE;
    end
  end

  // Load-use and branch-operand hazards on the instruction in D.
  always_comb begin
    w_lwstall = hz.MemtoRegE &&
                (reg_hit(hz.rsD, hz.writeregE) || reg_hit(hz.rtD, hz.writeregE));
    // Branch compares in D: a result still in E, or a load still in M,
    // cannot be forwarded in time.
    w_brstall = hz.branchD &&
                ((hz.RegWriteE &&
                  (reg_hit(hz.rsD, hz.writeregE) || reg_hit(hz.rtD, hz.writeregE))) ||
                 (hz.MemtoRegM &&
                  (reg_hit(hz.rsD, hz.writeregM) || reg_hit(hz.rtD, hz.writeregM))));
    w_stall   = w_lwstall || w_brstall || w_divbusy;
  end

  assign hz.forwardAE = w_fwd_ae;
  assign hz.forwardBE = w_fwd_be;
  assign hz.forwardAD = reg_hit(hz.rsD, hz.writeregM) && hz.RegWriteM;
  assign hz.forwardBD = reg_hit(hz.rtD, hz.writeregM) && hz.RegWriteM;

  assign hz.stallF   = w_stall;
  assign hz.stallD   = w_stall;
  assign hz.stallE   = w_divbusy;
  // While a divide holds E the D/E register is frozen, so no bubble there;
  // the bubble goes into E/M instead.
  assign hz.flushE   = (w_lwstall || w_brstall) && !w_divbusy;
  assign hz.flushM   = w_divbusy;
  // A redirect seen under stall is re-presented next cycle, so drop it now.
  assign hz.flushD   = hz.redirectD && !w_stall;
  assign hz.divdoneE = w_divdone;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: table of directed vectors, hand
// sequences for divide / reset corner cases, and randomized stimulus against
// a reference model that tracks a divide by its age in E.
// Output vector order: {stallF,stallD,stallE,flushD,flushE,flushM,
//                       forwardAD,forwardBD,forwardAE[1:0],forwardBE[1:0],divdoneE}
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int DIVC = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   age;   // -1: no divide in E; else cycles since the divide entered E

  hazard_ctrl_if hif ();

  hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .hz    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rsD, rtD, rsE, rtE, wE, wM, wW;
    logic        rwE, rwM, rwW, m2rE, m2rM, brD, redD;
    logic [12:0] exp;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW,
                              input logic rwE, rwM, rwW, m2rE, m2rM, brD, redD,
                              input logic [12:0] exp);
    vec_t v;
    v.rsD = rsD; v.rtD = rtD; v.rsE = rsE; v.rtE = rtE;
    v.wE = wE; v.wM = wM; v.wW = wW;
    v.rwE = rwE; v.rwM = rwM; v.rwW = rwW;
    v.m2rE = m2rE; v.m2rM = m2rM; v.brD = brD; v.redD = redD;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [12:0] obs();
    return {hif.stallF, hif.stallD, hif.stallE, hif.flushD, hif.flushE, hif.flushM,
            hif.forwardAD, hif.forwardBD, hif.forwardAE, hif.forwardBE, hif.divdoneE};
  endfunction

  function automatic bit hit(input logic [4:0] d, input logic [4:0] s);
    return (d != 5'd0) && (d == s);
  endfunction

  // Reference model: outputs from the textual hazard rules and divide age.
  function automatic logic [12:0] model();
    bit dep_e, dep_m, lw, br, busy, done, stall;
    logic [1:0] ae, be;
    dep_e = hit(hif.writeregE, hif.rsD) || hit(hif.writeregE, hif.rtD);
    dep_m = hit(hif.writeregM, hif.rsD) || hit(hif.writeregM, hif.rtD);
    lw = hif.MemtoRegE && dep_e;
    br = hif.branchD && ((hif.RegWriteE && dep_e) || (hif.MemtoRegM && dep_m));
`ifdef HAZ_DIV_EN
    busy = (age < 0) ? bit'(hif.divstartE) : (age < DIVC - 1);
    done = (age == DIVC - 1);
`else
    busy = 1'b0;
    done = hif.divstartE;
`endif
    ae = (hif.RegWriteM && hit(hif.writeregM, hif.rsE)) ? 2'd2 :
         (hif.RegWriteW && hit(hif.writeregW, hif.rsE)) ? 2'd1 : 2'd0;
    be = (hif.RegWriteM && hit(hif.writeregM, hif.rtE)) ? 2'd2 :
         (hif.RegWriteW && hit(hif.writeregW, hif.rtE)) ? 2'd1 : 2'd0;
    stall = lw || br || busy;
    return {stall, stall, busy, hif.redirectD && !stall, (lw || br) && !busy, busy,
            hif.RegWriteM && hit(hif.writeregM, hif.rsD),
            hif.RegWriteM && hit(hif.writeregM, hif.rtD), ae, be, done};
  endfunction

  task automatic cmp(input string name, input logic [12:0] got, input logic [12:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Advance the model across the coming clock edge.
  task automatic advance();
    if (!rst_n) age = -1;
    else if (age < 0) age = hif.divstartE ? 0 : -1;
    else if (age >= DIVC - 1) age = -1;
    else age = age + 1;
  endtask

  // Inputs are applied #1 after posedge; outputs are sampled #4 after posedge.
  task automatic check(input string name);
    #3;
    cmp(name, obs(), model());
    advance();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.rsD = 5'd0; hif.rtD = 5'd0; hif.rsE = 5'd0; hif.rtE = 5'd0;
    hif.writeregE = 5'd0; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
    hif.RegWriteE = 1'b0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.MemtoRegE = 1'b0; hif.MemtoRegM = 1'b0;
    hif.branchD = 1'b0; hif.redirectD = 1'b0; hif.divstartE = 1'b0;
  endtask

  logic [12:0] got;
  logic [4:0]  exp_div;

  initial begin
    total = 0;
    bad   = 0;
    age   = -1;
    rst_n = 1'b0;
    clear_inputs();

    //                rsD   rtD   rsE   rtE   wE    wM    wW   rwE  rwM  rwW  m2E  m2M  brD  red  {sF sD sE fD fE fM aD bD AE BE dd}
    vt[0]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_10_00_0);
    vt[1]  = mk(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_01_00_0);
    vt[2]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_00_00_0);
    vt[3]  = mk(5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 13'b1_1_0_0_1_0_0_0_00_00_0);
    vt[4]  = mk(5'd0, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_00_01_0);
    vt[5]  = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 13'b1_1_0_0_1_0_0_0_00_00_0);
    vt[6]  = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 13'b1_1_0_0_1_0_1_0_00_00_0);
    vt[7]  = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, 13'b0_0_0_0_0_0_1_0_00_00_0);
    vt[8]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 13'b0_0_0_1_0_0_0_0_00_00_0);
    vt[9]  = mk(5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 13'b1_1_0_0_1_0_0_0_00_00_0);
    vt[10] = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 13'b0_0_0_0_0_0_0_0_00_00_0);
    vt[11] = mk(5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_1_00_00_0);
    vt[12] = mk(5'd0, 5'd0, 5'd6, 5'd6, 5'd0, 5'd6, 5'd6, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_10_10_0);
    vt[13] = mk(5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 13'b0_0_0_0_0_0_0_0_00_00_0);

    // Reset state: everything quiet with quiet inputs.
    #2;
    cmp("reset_state", obs(), 13'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      tick();
      hif.rsD = vt[i].rsD; hif.rtD = vt[i].rtD; hif.rsE = vt[i].rsE; hif.rtE = vt[i].rtE;
      hif.writeregE = vt[i].wE; hif.writeregM = vt[i].wM; hif.writeregW = vt[i].wW;
      hif.RegWriteE = vt[i].rwE; hif.RegWriteM = vt[i].rwM; hif.RegWriteW = vt[i].rwW;
      hif.MemtoRegE = vt[i].m2rE; hif.MemtoRegM = vt[i].m2rM;
      hif.branchD = vt[i].brD; hif.redirectD = vt[i].redD;
      #3;
      cmp($sformatf("vec%0d", i), obs(), vt[i].exp);
      advance();
    end

`ifdef HAZ_DIV_EN
    // Divide held DIVC cycles, with a load-use hazard and redirect mid-divide,
    // then a back-to-back divide. Expected {stallE,flushM,divdone,flushE,flushD}.
    for (int c = 0; c < 5; c++) begin
      tick();
      clear_inputs();
      hif.divstartE = 1'b1;
      if (c == 1 || c == 2) begin
        hif.MemtoRegE = 1'b1; hif.writeregE = 5'd9; hif.rsD = 5'd9; hif.redirectD = 1'b1;
      end
      exp_div = (c == 3) ? 5'b00100 : 5'b11000;
      #3;
      got = obs();
      cmp($sformatf("div_seq_c%0d", c),
          {8'd0, got[10], got[7], got[0], got[8], got[9]}, {8'd0, exp_div});
      advance();
    end
    for (int c = 0; c < DIVC + 1; c++) begin
      tick();
      hif.divstartE = (c < DIVC - 1) ? 1'b1 : 1'b0;
      check($sformatf("div_b2b_c%0d", c));
    end

    // Reset on cycle 2 of a divide: abandoned, no divdoneE afterwards.
    for (int c = 0; c < 2; c++) begin
      tick();
      clear_inputs();
      hif.divstartE = 1'b1;
      check($sformatf("div_rst_pre_c%0d", c));
    end
    tick();
    rst_n = 1'b0;
    hif.divstartE = 1'b0;
    #3;
    cmp("div_rst_mid", obs(), 13'd0);
    age = -1;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < DIVC + 1; c++) begin
      #3;
      cmp($sformatf("div_rst_post_c%0d", c), obs(), 13'd0);
      advance();
      tick();
    end
`else
    // Single-cycle divide: divdoneE mirrors divstartE and nothing stalls.
    tick();
    clear_inputs();
    hif.divstartE = 1'b1;
    #3;
    cmp("div_single_on", obs(), 13'b0_0_0_0_0_0_0_0_00_00_1);
    advance();
    tick();
    hif.divstartE = 1'b0;
    #3;
    cmp("div_single_off", obs(), 13'd0);
    advance();
    tick();
    hif.divstartE = 1'b1;
    rst_n = 1'b0;
    #3;
    cmp("div_single_rst", obs(), 13'b0_0_0_0_0_0_0_0_00_00_1);
    age = -1;
    tick();
    rst_n = 1'b1;
    hif.divstartE = 1'b0;
`endif

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 3000; n++) begin
      tick();
      hif.rsD = 5'($urandom_range(0, 3)); hif.rtD = 5'($urandom_range(0, 3));
      hif.rsE = 5'($urandom_range(0, 3)); hif.rtE = 5'($urandom_range(0, 3));
      hif.writeregE = 5'($urandom_range(0, 3));
      hif.writeregM = 5'($urandom_range(0, 3));
      hif.writeregW = 5'($urandom_range(0, 3));
      hif.RegWriteE = 1'($urandom_range(0, 1)); hif.RegWriteM = 1'($urandom_range(0, 1));
      hif.RegWriteW = 1'($urandom_range(0, 1)); hif.MemtoRegE = 1'($urandom_range(0, 1));
      hif.MemtoRegM = 1'($urandom_range(0, 1)); hif.branchD = 1'($urandom_range(0, 1));
      hif.redirectD = 1'($urandom_range(0, 1));
      hif.divstartE = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if (n % 500 == 250) rst_n = 1'b0;
      else rst_n = 1'b1;
      check("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Drives the stall/flush controls of the F/D, D/E and E/M pipeline registers and the forwarding muxes in D and E. Sequences multi-cycle divide occupancy of the execute stage through a small state machine. Sits beside the datapath, sampling register addresses and control bits from D, E, M and W.

## Interface
- DIV_CYCLES, 32, total cycles a divide occupies E (must be >= 2)
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- rsD, rtD  input  5  source registers of instruction in D
- rsE, rtE  input  5  source registers of instruction in E
- writeregE, writeregM, writeregW  input  5  destination register per stage
- RegWriteE, RegWriteM, RegWriteW  input  1  destination write enable per stage
- MemtoRegE, MemtoRegM  input  1  load in E / M
- branchD  input  1  branch compare in D
- redirectD  input  1  taken branch/jump resolved in D
- divstartE  input  1  divide instruction present in E
- stallF, stallD, stallE  output  1  hold PC / F-D / D-E registers
- flushD, flushE, flushM  output  1  bubble into F-D / D-E / E-M registers
- forwardAD, forwardBD  output  1  D-stage forward from M
- forwardAE, forwardBE  output  2  E-stage forward select
- divdoneE  output  1  divide result valid this cycle

## Operation
- Register r0 never matches: every comparison below requires the register field != 0.
- forwardAE = FWD_MEM (2'b10) if rsE==writeregM && RegWriteM; else FWD_WB (2'b01) if rsE==writeregW && RegWriteW; else FWD_NONE (2'b00). forwardBE identical using rtE. M wins over W.
- forwardAD = rsD==writeregM && RegWriteM; forwardBD likewise with rtD.
- lwstall = MemtoRegE && writeregE in {rsD, rtD}.
- brstall = branchD && ((RegWriteE && writeregE in {rsD, rtD}) || (MemtoRegM && writeregM in {rsD, rtD})).
- divbusy = (state==IDLE && divstartE) || (state==BUSY && cnt!=0).
- stallF = stallD = lwstall | brstall | divbusy; stallE = divbusy.
- flushE = (lwstall | brstall) & ~divbusy; flushM = divbusy.
- flushD = redirectD & ~stallD (a redirect under stall is re-evaluated next cycle).
- Div FSM, states IDLE, BUSY, 5-bit-or-wider down-counter cnt ($clog2(DIV_CYCLES)):
  - IDLE, divstartE=1: cnt <= DIV_CYCLES-2, go BUSY.
  - BUSY, cnt!=0: cnt <= cnt-1; divstartE ignored (same instruction held).
  - BUSY, cnt==0: divdoneE=1, stalls drop, go IDLE; the divide leaves E this cycle.
- A back-to-back divide entering E the cycle after divdoneE restarts from IDLE normally.

## Timing
- Forward, stall and flush outputs are combinational from inputs and registered state; no added latency.
- Divide in E at cycle N (IDLE): stalls asserted cycles N..N+DIV_CYCLES-2; divdoneE at N+DIV_CYCLES-1; E occupancy exactly DIV_CYCLES cycles.
- Reset (reset=0, any time): state IDLE, cnt 0 immediately; divdoneE 0. Combinational outputs follow inputs with state IDLE. Reset mid-divide abandons the divide with no divdoneE.

## Configuration
- HAZ_DIV_EN defined: FSM, counter, divdoneE as above.
- HAZ_DIV_EN undefined: no state; divbusy=0, stallE=0, flushM=0, divdoneE=divstartE (single-cycle divide). Ports unchanged.

## Structure
- hazard_pkg: FWD_NONE/FWD_WB/FWD_MEM constants, IDLE/BUSY state encoding.
- One sub-module, div_stall_fsm (state, counter, divbusy, divdoneE), instantiated only under HAZ_DIV_EN.

## Test plan
- rsE=5, writeregM=5, RegWriteM=1, writeregW=5, RegWriteW=1 -> forwardAE=2'b10; drop RegWriteM -> 2'b01; rsE=0 -> 2'b00.
- MemtoRegE=1, writeregE=8, rtD=8 -> stallF=stallD=flushE=1 for one cycle, forwardBE picks W the next cycle.
- branchD=1, rsD=3, RegWriteE=1, writeregE=3 -> stall 1 cycle; then MemtoRegM=1, writeregM=3 -> stall again; then forwardAD=1 when only RegWriteM matches.
- DIV_CYCLES=4, divstartE pulse held 4 cycles -> stallE=flushM=1 cycles 0-2, divdoneE=1 cycle 3, state IDLE cycle 4.
- Divide in BUSY with lwstall also true -> flushE=0, flushM=1; redirectD=1 during stall -> flushD=0.
- reset=0 at cycle 2 of a DIV_CYCLES=4 divide -> state IDLE, divdoneE never asserted; build without HAZ_DIV_EN -> divdoneE mirrors divstartE, no stalls.
